// File: rtl/zoned_alarm_controller.sv
// zoned_alarm_controller: multi-zone alarm FSM with prescaled exit/entry timers and zone alarm memory.
// Define ALARM_TIMEOUT_EN to auto re-arm after SIREN_TIMEOUT ticks of siren.
module zoned_alarm_controller #(
  parameter int NUM_ZONES     = 8,
  parameter int CLK_DIV       = 50000000,
  parameter int EXIT_DELAY    = 5,
  parameter int ENTRY_DELAY   = 10,
  parameter int SIREN_TIMEOUT = 30
) (
  input  logic                 CLOCK_IN,
  input  logic                 RESET,
  input  logic                 ARM_REQ,
  input  logic                 DISARM_REQ,
  input  logic                 PANIC_REQ,
  input  logic [NUM_ZONES-1:0] ZONE_IN,
  input  logic [NUM_ZONES-1:0] ZONE_BYPASS,
  input  logic [NUM_ZONES-1:0] ZONE_INSTANT,
  output logic                 SIREN_LED,
  output logic                 STROBE_LED,
  output logic [NUM_ZONES-1:0] ZONE_LATCH,
  output logic                 ARMED_LED,
  output logic                 DISARMED_LED,
  output logic [2:0]           STATE
);
  localparam int MAXA = EXIT_DELAY > ENTRY_DELAY ? EXIT_DELAY : ENTRY_DELAY;
  localparam int MAXD = MAXA > SIREN_TIMEOUT ? MAXA : SIREN_TIMEOUT;
  localparam int TW   = $clog2(MAXD) + 1;
  localparam int PW   = $clog2(CLK_DIV);
  typedef enum logic [2:0] {
    DISARMED = 3'd0, EXIT = 3'd1, ARMED = 3'd2, ENTRY = 3'd3, ALARM = 3'd4, PANIC = 3'd5
  } state_t;
  state_t               state_q, state_d;
  logic [PW-1:0]        presc_q;
  logic [TW-1:0]        timer_q, load_d;
  logic [NUM_ZONES-1:0] act, inst, dly;
  logic                 tick, expire, chg, alarming;
  assign act      = ZONE_IN & ~ZONE_BYPASS;
  assign inst     = act & ZONE_INSTANT;
  assign dly      = act & ~ZONE_INSTANT;
  assign tick     = presc_q == PW'(CLK_DIV - 1);
  assign expire   = tick && timer_q <= TW'(1);
  assign chg      = state_d != state_q;
  assign alarming = state_d == ALARM || state_d == PANIC;
  assign STATE    = state_q;
  always_comb begin
    state_d = state_q;
    if (PANIC_REQ) state_d = PANIC;
    else if (DISARM_REQ && state_q != DISARMED) state_d = DISARMED;
    else
      case (state_q)
        DISARMED: state_d = ARM_REQ ? EXIT : DISARMED;
        EXIT:     state_d = expire ? ARMED : EXIT;
        ARMED:    state_d = |inst ? ALARM : |dly ? ENTRY : ARMED;
        ENTRY:    state_d = (|inst || expire) ? ALARM : ENTRY;
`ifdef ALARM_TIMEOUT_EN
        ALARM:    state_d = expire ? ARMED : ALARM;
`else
        ALARM:    state_d = ALARM;
`endif
        PANIC:    state_d = PANIC;
        default:  state_d = DISARMED;
      endcase
  end
`ifdef ALARM_TIMEOUT_EN
  assign load_d = state_d == EXIT ? TW'(EXIT_DELAY) : state_d == ENTRY ? TW'(ENTRY_DELAY) :
                  state_d == ALARM ? TW'(SIREN_TIMEOUT) : '0;
`else
  assign load_d = state_d == EXIT ? TW'(EXIT_DELAY) : state_d == ENTRY ? TW'(ENTRY_DELAY) : '0;
`endif
  always_ff @(posedge CLOCK_IN) begin
    if (RESET) begin
      state_q      <= DISARMED;
      presc_q      <= '0;
      timer_q      <= '0;
      ZONE_LATCH   <= '0;
      SIREN_LED    <= 1'b0;
      STROBE_LED   <= 1'b0;
      ARMED_LED    <= 1'b0;
      DISARMED_LED <= 1'b1;
    end else begin
      state_q      <= state_d;
      presc_q      <= (chg || tick) ? '0 : presc_q + 1'b1;
      timer_q      <= chg ? load_d : (tick && timer_q != '0) ? timer_q - 1'b1 : timer_q;
      ZONE_LATCH   <= (state_q == DISARMED && state_d == EXIT) ? '0 :
                      (state_q == ARMED || state_q == ENTRY || state_q == ALARM) ? ZONE_LATCH | act :
                      ZONE_LATCH;
      SIREN_LED    <= alarming;
      // strobe restarts low on entering an alarming state, then flips on every tick
      STROBE_LED   <= alarming && !chg && (STROBE_LED ^ tick);
      ARMED_LED    <= state_d == ARMED || state_d == ENTRY || alarming;
      DISARMED_LED <= state_d == DISARMED || state_d == EXIT;
    end
  end
endmodule
